// File: rtl/split_eval.sv
// Streaming constraint evaluator: checks one variable per beat against a
// per-variable mask/value table and emits one verdict per assignment vector.
module split_eval #(
    parameter  int unsigned NUM_VARS = 50,
    parameter  int unsigned VAR_W    = 16,
    localparam int unsigned IDX_W    = $clog2(NUM_VARS),
    localparam int unsigned CNT_W    = $clog2(NUM_VARS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [VAR_W-1:0] cfg_mask,
    input  logic [VAR_W-1:0] cfg_value,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAR_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sat,
    output logic [IDX_W-1:0] out_fail_idx,
    output logic [CNT_W-1:0] out_fail_cnt,
    output logic             busy
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VARS);

    logic [VAR_W-1:0] mask_tbl  [NUM_VARS];
    logic [VAR_W-1:0] value_tbl [NUM_VARS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             sat_acc_q, sat_acc_d;
    logic [IDX_W-1:0] fail_idx_acc_q, fail_idx_acc_d;
    logic [CNT_W-1:0] fail_cnt_acc_q, fail_cnt_acc_d;
    logic             sat_q, sat_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    logic             beat_pass;
    logic             fire;
    logic             nxt_sat;
    logic [IDX_W-1:0] nxt_idx;
    logic [CNT_W-1:0] nxt_cnt;

    // Table is read before any same-cycle write lands, so a colliding beat sees the old entry
    assign beat_pass = ((in_data ^ value_tbl[beat_cnt_q]) & mask_tbl[beat_cnt_q]) == '0;
    assign fire      = in_valid && (state_q == ACCUM);

    assign nxt_sat = sat_acc_q & beat_pass;
    assign nxt_idx = (!beat_pass && (fail_cnt_acc_q == '0)) ? beat_cnt_q : fail_idx_acc_q;
    assign nxt_cnt = (!beat_pass && (fail_cnt_acc_q != CNT_MAX))
                   ? fail_cnt_acc_q + CNT_W'(1) : fail_cnt_acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_VARS); i++) begin
                mask_tbl[i]  <= '0;
                value_tbl[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_idx) < NUM_VARS)) begin
            mask_tbl[cfg_idx]  <= cfg_mask;
            value_tbl[cfg_idx] <= cfg_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            beat_cnt_q     <= '0;
            sat_acc_q      <= 1'b1;
            fail_idx_acc_q <= '0;
            fail_cnt_acc_q <= '0;
            sat_q          <= 1'b1;
            fail_idx_q     <= '0;
            fail_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            sat_acc_q      <= sat_acc_d;
            fail_idx_acc_q <= fail_idx_acc_d;
            fail_cnt_acc_q <= fail_cnt_acc_d;
            sat_q          <= sat_d;
            fail_idx_q     <= fail_idx_d;
            fail_cnt_q     <= fail_cnt_d;
        end
    end

    // Accumulators are cleared as the verdict is loaded, so DONE only has to wait for out_ready
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        sat_acc_d      = sat_acc_q;
        fail_idx_acc_d = fail_idx_acc_q;
        fail_cnt_acc_d = fail_cnt_acc_q;
        sat_d          = sat_q;
        fail_idx_d     = fail_idx_q;
        fail_cnt_d     = fail_cnt_q;

        if (clr) begin
            state_d        = ACCUM;
            beat_cnt_d     = '0;
            sat_acc_d      = 1'b1;
            fail_idx_acc_d = '0;
            fail_cnt_acc_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (fire) begin
                        if (beat_cnt_q == LAST_IDX) begin
                            sat_d          = nxt_sat;
                            fail_idx_d     = nxt_idx;
                            fail_cnt_d     = nxt_cnt;
                            state_d        = DONE;
                            beat_cnt_d     = '0;
                            sat_acc_d      = 1'b1;
                            fail_idx_acc_d = '0;
                            fail_cnt_acc_d = '0;
                        end else begin
                            sat_acc_d      = nxt_sat;
                            fail_idx_acc_d = nxt_idx;
                            fail_cnt_acc_d = nxt_cnt;
                            beat_cnt_d     = beat_cnt_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q == DONE) || (beat_cnt_q != '0);
    assign out_sat      = sat_q;
    assign out_fail_idx = fail_idx_q;
    assign out_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_split_eval.sv
// Directed bench for split_eval: table-driven vectors plus hand-written
// sequences for backpressure, clr, config collision and mid-vector reset.
module tb_split_eval;

    localparam int unsigned NV = 50;
    localparam int unsigned VW = 16;
    localparam int unsigned IW = 6;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [VW-1:0] cfg_mask;
    logic [VW-1:0] cfg_value;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sat;
    logic [IW-1:0] out_fail_idx;
    logic [CW-1:0] out_fail_cnt;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [VW-1:0] vec [NV];

    typedef struct packed {
        logic [1:0]    n_cfg;
        logic [IW-1:0] c0_idx;
        logic [VW-1:0] c0_mask;
        logic [VW-1:0] c0_val;
        logic [IW-1:0] c1_idx;
        logic [VW-1:0] c1_mask;
        logic [VW-1:0] c1_val;
        logic [VW-1:0] d0;
        logic [VW-1:0] d3;
        logic [VW-1:0] d7;
        logic [VW-1:0] d30;
        logic [VW-1:0] d49;
        logic          exp_sat;
        logic [IW-1:0] exp_idx;
        logic [CW-1:0] exp_cnt;
    } rec_t;

    rec_t recs [7];

    split_eval #(.NUM_VARS(NV), .VAR_W(VW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_mask     (cfg_mask),
        .cfg_value    (cfg_value),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sat      (out_sat),
        .out_fail_idx (out_fail_idx),
        .out_fail_cnt (out_fail_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [VW-1:0] m, input logic [VW-1:0] v);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_mask  = m;
        cfg_value = v;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic fill_vec(input logic [VW-1:0] d0, input logic [VW-1:0] d3, input logic [VW-1:0] d7,
                            input logic [VW-1:0] d30, input logic [VW-1:0] d49);
        for (int i = 0; i < int'(NV); i++) vec[i] = VW'($urandom);
        vec[0]  = d0;
        vec[3]  = d3;
        vec[7]  = d7;
        vec[30] = d30;
        vec[49] = d49;
    endtask

    // Drives beats lo..hi-1, one per cycle, and returns one negedge after the last handshake
    task automatic stream_beats(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            chk("in_ready_beat", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = vec[i];
        end
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_verdict(input logic s, input logic [IW-1:0] idx, input logic [CW-1:0] cnt);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        chk("out_sat", 32'(out_sat), 32'(s));
        chk("out_fail_idx", 32'(out_fail_idx), 32'(idx));
        chk("out_fail_cnt", 32'(out_fail_cnt), 32'(cnt));
    endtask

    task automatic chk_idle();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        //            n  c0                           c1                           d0        d3        d7        d30       d49       sat  idx    cnt
        recs[0] = '{2'd0, 6'd0,  16'h0000, 16'h0000, 6'd0,  16'h0000, 16'h0000, 16'hFFFF, 16'h5555, 16'h0000, 16'h0000, 16'h1234, 1'b1, 6'd0,  6'd0};
        recs[1] = '{2'd2, 6'd7,  16'h00FF, 16'h0012, 6'd30, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'hAB12, 16'h7FFF, 16'h0000, 1'b0, 6'd30, 6'd1};
        recs[2] = '{2'd1, 6'd3,  16'hFFFF, 16'h0000, 6'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0013, 16'h7FFF, 16'h0000, 1'b0, 6'd3,  6'd3};
        recs[3] = '{2'd1, 6'd55, 16'hFFFF, 16'h0000, 6'd0,  16'h0000, 16'h0000, 16'h9999, 16'h0000, 16'h5512, 16'h8001, 16'hFFFF, 1'b1, 6'd0,  6'd0};
        recs[4] = '{2'd1, 6'd49, 16'h0001, 16'h0001, 6'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 16'h8000, 16'h0000, 1'b0, 6'd49, 6'd1};
        recs[5] = '{2'd1, 6'd0,  16'hF000, 16'hA000, 6'd0,  16'h0000, 16'h0000, 16'hB000, 16'hFFFF, 16'h0012, 16'h8000, 16'h0003, 1'b0, 6'd0,  6'd2};
        recs[6] = '{2'd0, 6'd0,  16'h0000, 16'h0000, 6'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 1'b0, 6'd0,  6'd5};

        rst_n = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_value = '0;
        clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd1);
        chk("rst_fail_idx", 32'(out_fail_idx), 32'd0);
        chk("rst_fail_cnt", 32'(out_fail_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors; table programming accumulates from one record to the next
        for (int r = 0; r < 7; r++) begin
            if (recs[r].n_cfg >= 2'd1) cfg_write(recs[r].c0_idx, recs[r].c0_mask, recs[r].c0_val);
            if (recs[r].n_cfg >= 2'd2) cfg_write(recs[r].c1_idx, recs[r].c1_mask, recs[r].c1_val);
            fill_vec(recs[r].d0, recs[r].d3, recs[r].d7, recs[r].d30, recs[r].d49);
            stream_beats(0, NV);
            chk_verdict(recs[r].exp_sat, recs[r].exp_idx, recs[r].exp_cnt);
            @(negedge clk);
            chk_idle();
        end

        // Backpressure: verdict held, beats refused, next vector starts at beat 0
        out_ready = 1'b0;
        fill_vec(16'hB000, 16'h0000, 16'h0012, 16'h8000, 16'h0001);
        stream_beats(0, NV);
        chk_verdict(1'b0, 6'd0, 6'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0000;
            @(negedge clk);
            chk_verdict(1'b0, 6'd0, 6'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle();
        out_ready = 1'b1;
        fill_vec(16'hA000, 16'h0000, 16'h0012, 16'h8000, 16'h0001);
        stream_beats(0, NV);
        chk_verdict(1'b1, 6'd0, 6'd0);
        @(negedge clk);

        // clr at beat 20 drops the partial vector, including its failures
        fill_vec(16'hB000, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        stream_beats(0, 20);
        chk("busy_mid", 32'(busy), 32'd1);
        in_valid = 1'b1;
        in_data  = vec[20];
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk_idle();
        fill_vec(16'hA000, 16'h0000, 16'h0012, 16'h8000, 16'h0001);
        stream_beats(0, NV);
        chk_verdict(1'b1, 6'd0, 6'd0);
        @(negedge clk);

        // Write entry 5 while beat 5 is being accepted: old entry applies to this vector
        fill_vec(16'hA000, 16'h0000, 16'h0012, 16'h8000, 16'h0001);
        vec[5] = 16'h0000;
        stream_beats(0, 5);
        in_valid  = 1'b1;
        in_data   = vec[5];
        cfg_we    = 1'b1;
        cfg_idx   = 6'd5;
        cfg_mask  = 16'hFFFF;
        cfg_value = 16'h1234;
        stream_beats(6, NV);
        chk_verdict(1'b1, 6'd0, 6'd0);
        @(negedge clk);
        stream_beats(0, NV);
        chk_verdict(1'b0, 6'd5, 6'd1);
        @(negedge clk);

        // Reset mid-vector returns everything, including the table, to reset values
        stream_beats(0, 10);
        chk("busy_pre_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_sat", 32'(out_sat), 32'd1);
        chk("mrst_fail_idx", 32'(out_fail_idx), 32'd0);
        chk("mrst_fail_cnt", 32'(out_fail_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_vec(16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        vec[5] = 16'h0000;
        stream_beats(0, NV);
        chk_verdict(1'b1, 6'd0, 6'd0);
        @(negedge clk);
        chk_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
